instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the MIPS_CPU core. Owns the fetch PC and issues word reads
//  to instruction memory over a valid/ready request channel. Buffers in-order responses
//  in a FETCH_DEPTH-entry FIFO and presents {instruction, instr_pc} to the core with

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel, redirect
// input and the instruction stream toward the core.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word reads, buffers responses
// in order and handles redirects. Define FETCH_PERF_EN for pop/stall perf counters.
//
// state | meaning
// FETCH | issuing requests, pushing responses into the FIFO
// DRAIN | discarding responses still in flight from before a redirect
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    localparam int            AW      = $clog2(FETCH_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FETCH_DEPTH);

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d, out_q, out_d, drop_q, drop_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            req_valid_q, req_valid_d;
    logic [31:0]     fifo_instr_q [FETCH_DEPTH];
    logic [31:0]     fifo_pc_q    [FETCH_DEPTH];
    logic            req_fire, rsp_fire, push, pop;
    logic            unused_rpc_bits;

    assign unused_rpc_bits = ^bus.redirect_pc[1:0];

    always_comb begin
        req_fire    = req_valid_q & bus.imem_req_ready;
        rsp_fire    = bus.imem_rsp_valid;
        pop         = (count_q != '0) & bus.instr_ready;
        push        = (state_q == FETCH) & rsp_fire & ~bus.redirect_valid;
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        count_d     = count_q;
        drop_d      = drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_d       = out_q + CW'(req_fire) - CW'(rsp_fire);
        if (req_fire)
            pc_d = pc_q + 32'd4;
        if (bus.redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            pc_d     = {bus.redirect_pc[31:2], 2'b00};
            rsp_pc_d = pc_d;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            drop_d   = out_d;
            state_d  = (out_d != '0) ? DRAIN : FETCH;
        end else begin
            if (state_q == DRAIN) begin
                drop_d = drop_q - CW'(rsp_fire);
                if (drop_d == '0)
                    state_d = FETCH;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        req_valid_d = (state_d == FETCH) && (({1'b0, count_d} + {1'b0, out_d}) < DEPTH_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            count_q     <= '0;
            out_q       <= '0;
            drop_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            req_valid_q <= 1'b0;
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            count_q     <= count_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            req_valid_q <= req_valid_d;
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
                fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
            end
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (count_q != '0);
    assign bus.instruction    = fifo_instr_q[rd_ptr_q];
    assign bus.instr_pc       = fifo_pc_q[rd_ptr_q];

    // The credit check reserves a FIFO slot for every request in flight.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && ({1'b0, count_q} == DEPTH_C)));

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (bus.instr_valid && bus.instr_ready)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (!bus.instr_valid && bus.instr_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with random latency, program-order
// stream model for requests and deliveries, directed scenarios then random traffic.
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } req_t;

    req_t        memq[$];
    int          cyc = 0, stale = 0, n_req = 0, n_del = 0, n_pop = 0, n_stall = 0;
    logic [31:0] exp_req = '0, exp_pc = '0, held_instr = '0, held_pc = '0;
    bit          hold = 0;

    task automatic cycle(input bit rr, input bit rsp_en, input bit ir, input bit rd,
                         input logic [31:0] rpc);
        bit rsp, rf, ifire;
        rsp = rsp_en && (memq.size() > 0);
        if (rsp) rsp = (memq[0].rdy <= cyc);
        bus.imem_req_ready = rr;
        bus.imem_rsp_valid = rsp;
        if (rsp) bus.imem_rsp_data = mem_word(memq[0].addr);
        else     bus.imem_rsp_data = $urandom;
        bus.instr_ready    = ir;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        if (hold) begin
            check("hold_instruction", bus.instruction, held_instr);
            check("hold_instr_pc", bus.instr_pc, held_pc);
        end
        if (bus.imem_req_valid && stale > 0)
            check("drain_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        rf    = bus.imem_req_valid && rr;
        ifire = bus.instr_valid && ir;
        if (rf) begin
            check("req_addr", bus.imem_req_addr, exp_req);
            memq.push_back('{bus.imem_req_addr, cyc + 1});
            exp_req += 32'd4;
            n_req++;
        end
        if (ifire) begin
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instruction", bus.instruction, mem_word(exp_pc));
            exp_pc += 32'd4;
            n_del++;
        end
        if (ifire) n_pop++;
        if (ir && !bus.instr_valid) n_stall++;
        if (rsp) begin
            void'(memq.pop_front());
            if (stale > 0) stale--;
        end
        if (rd) begin
            exp_req = {rpc[31:2], 2'b00};
            exp_pc  = exp_req;
            stale   = memq.size();
        end
        hold       = bus.instr_valid && !ir && !rd;
        held_instr = bus.instruction;
        held_pc    = bus.instr_pc;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_model();
        memq.delete();
        stale   = 0;
        hold    = 0;
        exp_req = '0;
        exp_pc  = '0;
        n_req   = 0;
        n_del   = 0;
        n_pop   = 0;
        n_stall = 0;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input bit rsp_en, input string tag);
        for (int i = 0; i < 40 && n_req < n; i++)
            cycle(1, rsp_en, 1, 0, '0);
        check(tag, 32'(n_req >= n), 32'd1);
    endtask

    initial begin
        int d0;
        // Reset values and a plain streaming run.
        do_reset();
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0);
        check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rst_instruction", bus.instruction, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        repeat (30) cycle(1, 1, 1, 0, '0);
        check("t1_progress", 32'(n_del >= 8), 32'd1);

        // Core stalled: credit limit then resume.
        do_reset();
        repeat (10) cycle(1, 1, 0, 0, '0);
        check("t2_req_count", n_req, DEPTH);
        check("t2_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("t2_head_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("t2_head_pc", bus.instr_pc, 32'h0);
        repeat (12) cycle(1, 1, 1, 0, '0);
        check("t2_resumed", 32'(n_req > DEPTH), 32'd1);

        // Redirect with two requests outstanding.
        do_reset();
        wait_reqs(2, 0, "t3_wait_reqs");
        cycle(0, 0, 1, 1, 32'h0000_0100);
        check("t3_drain_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("t3_stale", stale, 2);
        d0 = n_del;
        for (int i = 0; i < 40 && n_del == d0; i++)
            cycle(1, 1, 1, 0, '0);
        check("t3_delivered", 32'(n_del > d0), 32'd1);

        // Redirect to an unaligned target with a response in the same cycle.
        do_reset();
        wait_reqs(1, 0, "t4_wait_req");
        cycle(0, 1, 1, 1, 32'h0000_0103);
        check("t4_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("t4_req_addr", bus.imem_req_addr, 32'h0000_0100);
        repeat (10) cycle(1, 1, 1, 0, '0);

        // Wrap of the fetch PC at the top of the address space.
        cycle(1, 1, 1, 1, 32'hFFFF_FFFC);
        d0 = n_req;
        repeat (16) cycle(1, 1, 1, 0, '0);
        check("t5_wrapped", 32'(n_req >= d0 + 2), 32'd1);

        // Reset asserted while draining.
        do_reset();
        wait_reqs(2, 0, "t6_wait_reqs");
        cycle(0, 0, 1, 1, 32'h0000_0200);
        reset = 1'b1;
        #1;
        check("t6_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("t6_req_addr", bus.imem_req_addr, 32'h0);
        check("t6_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("t6_instruction", bus.instruction, 32'h0);
        check("t6_instr_pc", bus.instr_pc, 32'h0);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
`ifdef FETCH_PERF_EN
        check("t6_perf_fetch", perf_fetch_cnt, 32'd0);
        check("t6_perf_stall", perf_stall_cnt, 32'd0);
`endif
        repeat (10) cycle(1, 1, 1, 0, '0);
        check("t6_restart", 32'(n_del > 0), 32'd1);

        // Random traffic, random latency, random redirects.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           rpc = $urandom;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0, rpc);
        end
        check("rand_progress", 32'(n_del > 300), 32'd1);
`ifdef FETCH_PERF_EN
        check("rand_perf_fetch", perf_fetch_cnt, n_pop);
        check("rand_perf_stall", perf_stall_cnt, n_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
